// File: rtl/moore_prog.sv
// Programmable table-driven Moore machine. Transition and output tables are loaded at run time.
// The machine steps on i_ctrl_in and raises a sticky error on any illegal load or table write.
module moore_prog #(
  parameter int N_STATES = 4,
  parameter int IN_W     = 2,
  parameter int OUT_W    = 1,
  parameter int CNT_W    = 8,
  localparam int SW      = $clog2(N_STATES),
  localparam int N_SYM   = 2**IN_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [IN_W-1:0]  i_sw_in,
  input  logic             i_ctrl_in,
  input  logic             i_load_in,
  input  logic [SW-1:0]    i_state_in,
  input  logic             i_cfg_we,
  input  logic             i_cfg_out_we,
  input  logic [SW-1:0]    i_cfg_state,
  input  logic [IN_W-1:0]  i_cfg_sym,
  input  logic [SW-1:0]    i_cfg_next,
  input  logic [OUT_W-1:0] i_cfg_out,
  output logic [SW-1:0]    o_state,
  output logic [OUT_W-1:0] o_out,
  output logic             o_err,
  output logic [CNT_W-1:0] o_steps
);

  // One extra bit so the limit is representable when N_STATES is a power of two.
  localparam logic [SW:0] NS = (SW+1)'(N_STATES);

  logic [SW-1:0]    r_next_tab [N_STATES][N_SYM];
  logic [OUT_W-1:0] r_out_tab  [N_STATES];
  logic [SW-1:0]    r_state;
  logic [CNT_W-1:0] r_steps;
  logic             r_err;

  logic [SW-1:0]    w_state_nxt;
  logic [CNT_W-1:0] w_steps_nxt;
  logic             w_load_ok;
  logic             w_row_ok;
  logic             w_next_ok;
  logic             w_tab_wr;
  logic             w_out_wr;
  logic             w_err_set;

  always_comb begin
    w_load_ok   = {1'b0, i_state_in}  < NS;
    w_row_ok    = {1'b0, i_cfg_state} < NS;
    w_next_ok   = {1'b0, i_cfg_next}  < NS;
    w_tab_wr    = i_cfg_we && w_row_ok && w_next_ok;
    w_out_wr    = i_cfg_out_we && w_row_ok;
    w_err_set   = (i_load_in && !w_load_ok)
                || ((i_cfg_we || i_cfg_out_we) && !w_row_ok)
                || (i_cfg_we && !w_next_ok);
    w_state_nxt = r_state;
    w_steps_nxt = r_steps;
    if (i_load_in) begin
      if (w_load_ok) begin
        w_state_nxt = i_state_in;
        w_steps_nxt = '0;
      end
    end else if (i_ctrl_in) begin
      // Reads the registered table, so a same-cycle write is seen only by the next step.
      w_state_nxt = r_next_tab[r_state][i_sw_in];
      if (r_steps != '1) begin
        w_steps_nxt = r_steps + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= '0;
      r_steps <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_steps <= w_steps_nxt;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int s = 0; s < N_STATES; s++) begin
        r_out_tab[s] <= '0;
        for (int x = 0; x < N_SYM; x++) begin
          r_next_tab[s][x] <= SW'(s);
        end
      end
    end else begin
      if (w_tab_wr) begin
        r_next_tab[i_cfg_state][i_cfg_sym] <= i_cfg_next;
      end
      if (w_out_wr) begin
        r_out_tab[i_cfg_state] <= i_cfg_out;
      end
    end
  end

  assign o_state = r_state;
  assign o_out   = r_out_tab[r_state];
  assign o_err   = r_err;
  assign o_steps = r_steps;

endmodule

// File: doc/moore_prog.md
# moore_prog

Programmable, table-driven Moore state machine: the parametrised successor of the fixed 2-state switch-driven Moore machine. State count, input-symbol width and output width are parameters. The transition and output tables are written at run time through a configuration port, and the machine advances only on a `ctrl_in` step strobe. It sits between the switch/debounce front end and the LED/output logic. A separate configuration sequencer loads the tables and the initial state.

## Interface

Parameters:
- `N_STATES`, 4, number of states; must be >= 2; `SW = $clog2(N_STATES)`.
- `IN_W`, 2, width of the input symbol `sw_in`; the table has `2**IN_W` columns.
- `OUT_W`, 1, width of the Moore output.
- `CNT_W`, 8, width of the step counter.

Ports:
- `clk`, in, 1, the single clock.
- `reset`, in, 1, asynchronous, active-high.
- `sw_in`, in, `IN_W`, current input symbol.
- `ctrl_in`, in, 1, step enable; while high, the machine takes one transition per clock.
- `load_in`, in, 1, load `state_in` into `state`.
- `state_in`, in, `SW`, state value to load.
- `cfg_we`, in, 1, write the transition entry `next_tab[cfg_state][cfg_sym] = cfg_next`.
- `cfg_out_we`, in, 1, write the output entry `out_tab[cfg_state] = cfg_out`.
- `cfg_state`, in, `SW`, table row.
- `cfg_sym`, in, `IN_W`, table column.
- `cfg_next`, in, `SW`, next-state value.
- `cfg_out`, in, `OUT_W`, output value for the row.
- `state`, out, `SW`, current state (registered).
- `out`, out, `OUT_W`, Moore output: `out_tab[state]`.
- `err`, out, 1, sticky error flag.
- `steps`, out, `CNT_W`, count of steps taken, saturating.

## Operation

- Reset (async assert, sync deassert assumed at system level):
  - `state=0`, `err=0`, `steps=0`.
  - Every `next_tab[s][x]=s` (self-loop); every `out_tab[s]=0`, so `out=0`.
- Per-clock priority for the state register:
  1. reset
  2. `load_in`
  3. `ctrl_in`
  4. hold
- `load_in=1`:
  - If `state_in < N_STATES`: `state <= state_in` and `steps <= 0`.
  - Otherwise `state` holds, `steps` holds, `err <= 1`.
  - `ctrl_in` in the same cycle is ignored.
- `ctrl_in=1` with `load_in=0`:
  - `state <= next_tab[state][sw_in]`.
  - `steps <= steps+1`, saturating at `2**CNT_W-1`, with no wrap.
- Config writes are independent of stepping:
  - `cfg_we` and `cfg_out_we` may both be high in one cycle.
  - A write with `cfg_state >= N_STATES`, or with `cfg_we=1` and `cfg_next >= N_STATES`, is dropped and sets `err <= 1`.
  - Only the offending write is dropped; a legal companion write in the same cycle still takes effect.
- Same-cycle write and step: the step uses the pre-write table contents; the new entry is visible from the next cycle.
- `out` is a combinational read of the registered `out_tab` indexed by the registered `state`. It has no logic from `sw_in`, so it is a pure Moore output.
- `err` clears only on reset.
- Table entries and `state` never hold an out-of-range value; invalid writes and loads cannot create one.

## Timing

- Step latency: `ctrl_in` sampled high at edge k gives the new `state` after edge k; `out` follows in the same cycle, as a combinational read after the register.
- `load_in` latency: 1 clock.
- Config write latency: 1 clock before the entry affects a step or `out`. Writing `out_tab[state]` changes `out` after that edge without any state change.
- Reset mid-run: on assertion, `state`, `out`, `err`, `steps` and all tables return to reset values immediately, without waiting for `clk`. The first step after deassertion starts from state 0.
- Continuous `ctrl_in` gives one transition per clock, with no bubbles.

## Test plan

- **Legacy 2-state config** (`N_STATES=2`, `IN_W=2`):
  - Program rows:
    - row0: `{0->0, 1->1, 2->1, 3->1}`
    - row1: `{0->1, 1->0, 2->1, 3->0}`
  - Program outputs: `out0=1`, `out1=0`.
  - Step with `sw_in` sequence 0,2,3,1,2 -> `state` 0,1,0,1,1; `out` 1,0,1,0,0.
- **Reset defaults:** assert `reset` mid-sequence without a clock edge -> `state=0`, `out=0`, `err=0`, `steps=0` immediately. Stepping with any `sw_in` keeps `state=0` (self-loop).
- **Load and priority:**
  - `load_in=1`, `state_in=3`, `ctrl_in=1` in one cycle -> `state=3`, `steps=0`, no transition.
  - `state_in=5` with `N_STATES=5` -> `state` unchanged, `err=1`.
- **Write/step collision:** in a cycle with `ctrl_in=1` from state 2, `sw_in=1`, write `next_tab[2][1]=3` when the old entry is 1 -> `state=1`. The same step repeated later from state 2 -> `state=3`.
- **Illegal config:**
  - `cfg_we` with `cfg_next=N_STATES` -> entry unchanged, `err=1`, and `err` stays 1 through further legal writes until reset.
  - In the same cycle, a legal `cfg_out_we` takes effect.
- **Counter saturation** (`CNT_W=3`): 10 consecutive steps -> `steps` reads 1..7, then holds at 7. `load_in` -> `steps=0`.
